uart_echo_fifo: RTL and testbench

UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

---
 rtl/uart_echo_fifo.sv | 189 ++++++++++++++++++
 tb/tb_uart_echo_fifo.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_echo_fifo
// Brief    : Echoes UART receive characters to the transmitter through a FIFO.
//            Define UART_ECHO_CRLF_EN to append 0x0A after every echoed 0x0D.
// Revision : 1.0 - initial release
// ============================================================================
module uart_echo_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_available,
    output logic                  rx_clear_available,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_finish,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    input  logic                  overflow_clear
);

    localparam logic [DEPTH_LOG2:0]   c_full_count = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   c_count_one  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_ptr_one    = DEPTH_LOG2'(1);
`ifdef UART_ECHO_CRLF_EN
    localparam logic [DATA_WIDTH-1:0] c_cr = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] c_lf = DATA_WIDTH'(8'h0A);
`endif

    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_WAIT = 2'd1
`ifdef UART_ECHO_CRLF_EN
        ,
        TX_LF   = 2'd2
`endif
    } tx_state_t;

    rx_state_t             r_rx_state;
    rx_state_t             w_rx_state_next;
    tx_state_t             r_tx_state;
    tx_state_t             w_tx_state_next;

    logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic                  r_overflow;
    logic                  w_overflow_next;
    logic                  r_rx_clear;
    logic                  r_tx_start;
    logic                  w_tx_start_next;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [DATA_WIDTH-1:0] w_tx_data_next;

    logic                  w_full;
    logic                  w_rx_accept;
    logic                  w_push;
    logic                  w_pop;

    // Full is judged on the occupancy at the start of the cycle, so a
    // same-cycle pop never makes room for a push.
    assign w_full = (r_count == c_full_count);
    assign w_push = w_rx_accept && !w_full;

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_accept     = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (rx_available) begin
                    w_rx_accept     = 1'b1;
                    w_rx_state_next = RX_ACK;
                end
            end
            RX_ACK:  w_rx_state_next = RX_IDLE;
            default: w_rx_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_pop           = 1'b0;
        w_tx_start_next = 1'b0;
        w_tx_data_next  = r_tx_data;
        case (r_tx_state)
            TX_IDLE: begin
                if (r_count != '0) begin
                    w_pop           = 1'b1;
                    w_tx_start_next = 1'b1;
                    w_tx_data_next  = r_mem[r_rd_ptr];
                    w_tx_state_next = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (tx_finish) begin
                    w_tx_state_next = TX_IDLE;
`ifdef UART_ECHO_CRLF_EN
                    // tx_data still holds the popped character here, so an LF
                    // frame never re-triggers itself.
                    if (r_tx_data == c_cr) begin
                        w_tx_state_next = TX_LF;
                        w_tx_start_next = 1'b1;
                        w_tx_data_next  = c_lf;
                    end
`endif
                end
            end
`ifdef UART_ECHO_CRLF_EN
            TX_LF: begin
                if (tx_finish) begin
                    w_tx_state_next = TX_IDLE;
                end
            end
`endif
            default: w_tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_count_one;
            2'b01:   w_count_next = r_count - c_count_one;
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_overflow_next = r_overflow;
        if (w_rx_accept && w_full) begin
            w_overflow_next = 1'b1;
        end else if (overflow_clear) begin
            w_overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_tx_state <= TX_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_rx_clear <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_rx_state <= w_rx_state_next;
            r_tx_state <= w_tx_state_next;
            r_count    <= w_count_next;
            r_overflow <= w_overflow_next;
            r_rx_clear <= w_rx_accept;
            r_tx_start <= w_tx_start_next;
            r_tx_data  <= w_tx_data_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    assign rx_clear_available = r_rx_clear;
    assign tx_start           = r_tx_start;
    assign tx_data            = r_tx_data;
    assign fifo_count         = r_count;
    assign overflow           = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_echo_fifo
// Brief    : Self-checking bench for uart_echo_fifo (vectors, corner sequences,
//            random bursts against a queue model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_echo_fifo;

`ifdef UART_ECHO_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_available = 1'b0;
    logic       rx_clear_available;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_finish = 1'b0;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       overflow_clear = 1'b0;

    uart_echo_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rx_data            (rx_data),
        .rx_available       (rx_available),
        .rx_clear_available (rx_clear_available),
        .tx_start           (tx_start),
        .tx_data            (tx_data),
        .tx_finish          (tx_finish),
        .fifo_count         (fifo_count),
        .overflow           (overflow),
        .overflow_clear     (overflow_clear)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         first_start = 0;
    int         last_clr = 0;
    int         clr_cnt = 0;
    int         start_cnt = 0;
    bit         mon_busy = 1'b0;
    bit         hold_finish = 1'b0;
    bit         manual = 1'b0;
    int         fin_delay = 0;
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] ch;
        int         fin;
        logic [7:0] exp0;
        bit         lf;
    } vec_t;
    vec_t vecs [6];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Passive observer: records every launched frame and flags overlapping ones.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            mon_busy = 1'b0;
        end else begin
            if (rx_clear_available) begin
                clr_cnt++;
                last_clr = cyc;
            end
            if (tx_start) begin
                checks++;
                if (mon_busy) begin
                    errors++;
                    $display("FAIL tx_start_while_busy actual=1 expected=0 data=%02h", tx_data);
                end
                if (got_q.size() == 0) first_start = cyc;
                got_q.push_back(tx_data);
                start_cnt++;
                mon_busy = 1'b1;
            end else if (tx_finish) begin
                mon_busy = 1'b0;
            end
        end
    end

    // Transmitter stand-in: answers each frame with tx_finish after a delay.
    initial forever begin
        @(negedge clk);
        if (tx_start && rst_n && !manual) begin
            logic [7:0] exp_d;
            int         d;
            int         n;
            bit         ab;
            exp_d = tx_data;
            d     = (fin_delay > 0) ? fin_delay : int'($urandom_range(1, 8));
            n     = 0;
            ab    = 1'b0;
            while (!ab && (n < d || hold_finish)) begin
                @(posedge clk);
                n++;
                if (!rst_n) ab = 1'b1;
            end
            if (!ab) begin
                #1;
                checks++;
                if (tx_data !== exp_d) begin
                    errors++;
                    $display("FAIL tx_data_stable actual=%02h expected=%02h", tx_data, exp_d);
                end
                tx_finish = 1'b1;
                @(posedge clk);
                #1 tx_finish = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic check_seq(input string name, input logic [7:0] exp[$]);
        check({name, "_len"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_q.size(); i++)
            check(name, got_q[i], exp[i]);
    endtask

    // Reference model: every accepted character is echoed, CR optionally + LF.
    task automatic push_exp(input logic [7:0] c);
        exp_q.push_back(c);
        if (CRLF && c == 8'h0D) exp_q.push_back(8'h0A);
    endtask

    task automatic send_char(input logic [7:0] c);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        rx_data      = c;
        rx_available = 1'b1;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (rx_clear_available) ok = 1'b1;
            n++;
        end
        check("rx_ack", ok, 1);
        @(posedge clk);
        #1 rx_available = 1'b0;
    endtask

    task automatic wait_drain(input int n);
        int k;
        k = 0;
        while ((got_q.size() < n || mon_busy || fifo_count != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("drain_done", (k < 3000), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] e [$];
        logic [7:0] c;
        int         sc;
        int         len;

        vecs[0] = '{8'h41, 10, 8'h41, 1'b0};
        vecs[1] = '{8'h00, 1,  8'h00, 1'b0};
        vecs[2] = '{8'hFF, 3,  8'hFF, 1'b0};
        vecs[3] = '{8'h0D, 5,  8'h0D, CRLF};
        vecs[4] = '{8'h0A, 2,  8'h0A, 1'b0};
        vecs[5] = '{8'h7E, 7,  8'h7E, 1'b0};

        // Reset values, then a character on the very first edge after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_clear", rx_clear_available, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        got_q.delete();
        clr_cnt      = 0;
        fin_delay    = 10;
        rst_n        = 1'b1;
        rx_data      = 8'h41;
        rx_available = 1'b1;
        @(negedge clk);
        check("first_edge_accept", rx_clear_available, 1);
        @(posedge clk);
        #1 rx_available = 1'b0;
        wait_drain(1);
        e = '{8'h41};
        check_seq("echo_41", e);
        check("echo_41_latency", first_start - last_clr, 1);
        check("echo_41_clr_once", clr_cnt, 1);

        // Single-character vectors.
        for (int v = 0; v < 6; v++) begin
            got_q.delete();
            clr_cnt   = 0;
            fin_delay = vecs[v].fin;
            send_char(vecs[v].ch);
            e = '{vecs[v].exp0};
            if (vecs[v].lf) e.push_back(8'h0A);
            wait_drain(e.size());
            check_seq("vec", e);
            check("vec_latency", first_start - last_clr, 1);
            check("vec_clr_once", clr_cnt, 1);
            check("vec_overflow", overflow, 0);
        end

        // Burst of 16 while the transmitter is held.
        got_q.delete();
        exp_q.delete();
        fin_delay   = 2;
        hold_finish = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_char(8'(i));
            push_exp(8'(i));
        end
        check("burst_count", fifo_count, 15);
        check("burst_started", got_q.size(), 1);
        hold_finish = 1'b0;
        wait_drain(exp_q.size());
        check_seq("burst_order", exp_q);
        check("burst_overflow", overflow, 0);

        // Overflow: one frame in flight, 16 queued, two more dropped.
        got_q.delete();
        e = '{8'h55};
        hold_finish = 1'b1;
        send_char(8'h55);
        for (int i = 0; i < 18; i++) begin
            send_char(8'h60 + 8'(i));
            if (i < 16) e.push_back(8'h60 + 8'(i));
            if (i == 15) begin
                check("full_count", fifo_count, 16);
                check("full_no_overflow", overflow, 0);
            end
        end
        check("ovf_count", fifo_count, 16);
        check("ovf_set", overflow, 1);
        overflow_clear = 1'b1;
        @(posedge clk);
        #1 overflow_clear = 1'b0;
        check("ovf_cleared", overflow, 0);
        rx_data        = 8'h77;
        rx_available   = 1'b1;
        overflow_clear = 1'b1;
        @(posedge clk);
        #1 overflow_clear = 1'b0;
        check("ovf_set_beats_clear", overflow, 1);
        check("ovf_clear_ack", rx_clear_available, 1);
        @(posedge clk);
        #1 rx_available = 1'b0;
        overflow_clear = 1'b1;
        @(posedge clk);
        #1 overflow_clear = 1'b0;
        check("ovf_cleared2", overflow, 0);
        hold_finish = 1'b0;
        wait_drain(e.size());
        check_seq("ovf_order", e);

        // Push and pop on the same edge at occupancy 5, then wrap the pointers.
        got_q.delete();
        exp_q.delete();
        manual = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_char(8'hA0 + 8'(i));
            push_exp(8'hA0 + 8'(i));
        end
        @(negedge clk);
        check("pp_count_before", fifo_count, 5);
        @(posedge clk);
        #1 tx_finish = 1'b1;
        @(posedge clk);
        #1 tx_finish = 1'b0;
        rx_data      = 8'hA6;
        rx_available = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("pp_count_same", fifo_count, 5);
        check("pp_pop", tx_start, 1);
        check("pp_ack", rx_clear_available, 1);
        @(posedge clk);
        #1 rx_available = 1'b0;
        push_exp(8'hA6);
        for (int i = 7; i < 17; i++) begin
            send_char(8'hA0 + 8'(i));
            push_exp(8'hA0 + 8'(i));
        end
        check("wrap_count", fifo_count, 15);
        manual    = 1'b0;
        fin_delay = 0;
        tx_finish = 1'b1;
        @(posedge clk);
        #1 tx_finish = 1'b0;
        wait_drain(exp_q.size());
        check_seq("wrap_order", exp_q);

        // CR followed by a normal character.
        got_q.delete();
        fin_delay = 3;
        send_char(8'h0D);
        send_char(8'h42);
        if (CRLF) e = '{8'h0D, 8'h0A, 8'h42};
        else      e = '{8'h0D, 8'h42};
        wait_drain(e.size());
        check_seq("cr_seq", e);

        // Reset while a frame is in flight with three characters queued.
        got_q.delete();
        hold_finish = 1'b1;
        send_char(8'h11);
        send_char(8'h12);
        send_char(8'h13);
        send_char(8'h14);
        check("pre_rst_count", fifo_count, 3);
        rst_n = 1'b0;
        #2;
        check("arst_rx_clear", rx_clear_available, 0);
        check("arst_tx_start", tx_start, 0);
        check("arst_tx_data", tx_data, 0);
        check("arst_fifo_count", fifo_count, 0);
        check("arst_overflow", overflow, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        hold_finish = 1'b0;
        sc          = start_cnt;
        repeat (30) @(negedge clk);
        check("no_start_after_rst", start_cnt - sc, 0);
        check("post_rst_count", fifo_count, 0);
        @(posedge clk);
        #1;
        got_q.delete();
        send_char(8'h99);
        wait_drain(1);
        e = '{8'h99};
        check_seq("post_rst_echo", e);

        // Random bursts (never more than DEPTH outstanding).
        for (int b = 0; b < 8; b++) begin
            got_q.delete();
            exp_q.delete();
            fin_delay = 0;
            len = int'($urandom_range(1, 16));
            for (int i = 0; i < len; i++) begin
                c = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) c = 8'h0D;
                send_char(c);
                push_exp(c);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            wait_drain(exp_q.size());
            check_seq("rand", exp_q);
            check("rand_overflow", overflow, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
